// File: rtl/program_loader_pkg.sv
// Shared types and widths for the program loader: FSM states and stream/word geometry.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loaderState_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned LEN_W          = 15;
  localparam int unsigned ADDR_W         = 32;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Big-endian byte packer: holds the first three bytes of a word and presents the full
// word combined with the byte on ByteIn, so the word is usable on the edge of its 4th byte.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Shift,
  input  logic              Clear,
  input  logic [BYTE_W-1:0] ByteIn,
  output logic [WORD_W-1:0] Word,
  output logic              Full
);

  localparam int unsigned HOLD_W = WORD_W - BYTE_W;

  logic [HOLD_W-1:0] holdReg;
  logic [IDX_W-1:0]  byteIdx;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      holdReg <= '0;
      byteIdx <= '0;
    end else if (Clear) begin
      holdReg <= '0;
      byteIdx <= '0;
    end else if (Shift) begin
      holdReg <= {holdReg[HOLD_W-BYTE_W-1:0], ByteIn};
      byteIdx <= byteIdx + IDX_W'(1);
    end
  end

  // Full means the next shifted byte completes the word; the index wraps back to 0.
  assign Full = (byteIdx == IDX_W'(BYTES_PER_WORD - 1));
  assign Word = {holdReg, ByteIn};

endmodule

// File: rtl/program_loader.sv
// Loads a big-endian byte stream into instruction/data RAM as 32-bit words and holds
// the pipeline in reset until the whole image has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 16384
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [LEN_W-1:0]  Length,
  input  logic [BYTE_W-1:0] ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [WORD_W-1:0] Mem_WriteData,
  output logic              Mem_MemWrite,
  output logic              CPU_Reset,
  output logic              Done,
  output logic              Error,
  output logic [LEN_W-1:0]  WordCount
);

  localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};

  loaderState_t      state, stateNext;
  logic [LEN_W-1:0]  lengthReg;
  logic [WORD_W-1:0] packWord;
  logic              packFull;
  logic              xfer, startLoad, startEmpty, startBad, wordDone;

  assign xfer = ByteValid && ByteReady && (state == RECV);

  byte_packer uPacker (
    .Clock  (Clock),
    .Reset  (Reset),
    .Shift  (xfer),
    .Clear  (startLoad || startEmpty),
    .ByteIn (ByteIn),
    .Word   (packWord),
    .Full   (packFull)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Start is only honoured from IDLE or DONE; a finished image can be reloaded.
  always_comb begin
    stateNext  = state;
    startLoad  = 1'b0;
    startEmpty = 1'b0;
    startBad   = 1'b0;
    wordDone   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          if (Length == '0) begin
            startEmpty = 1'b1;
            stateNext  = DONE;
          end else if (32'(Length) > 32'(MAX_WORDS)) begin
            startBad  = 1'b1;
            stateNext = IDLE;
          end else begin
            startLoad = 1'b1;
            stateNext = RECV;
          end
        end
      end
      RECV: begin
        if (xfer && packFull) stateNext = WRITE;
      end
      WRITE: begin
        wordDone  = 1'b1;
        stateNext = ((WordCount + LEN_W'(1)) == lengthReg) ? DONE : RECV;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Handshake/status outputs are registered decodes of the next state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ByteReady     <= 1'b0;
      Mem_MemWrite  <= 1'b0;
      Mem_Address   <= BASE_ALIGNED;
      Mem_WriteData <= '0;
      CPU_Reset     <= 1'b1;
      Done          <= 1'b0;
      Error         <= 1'b0;
      WordCount     <= '0;
      lengthReg     <= '0;
    end else begin
      ByteReady    <= (stateNext == RECV);
      Mem_MemWrite <= (stateNext == WRITE);
      Done         <= (stateNext == DONE);
      CPU_Reset    <= (stateNext != DONE);
      if (startLoad || startEmpty) begin
        Error     <= 1'b0;
        WordCount <= '0;
        lengthReg <= Length;
      end
      if (startLoad) Mem_Address <= BASE_ALIGNED;
      if (startBad)  Error <= 1'b1;
      if (xfer && packFull) Mem_WriteData <= packWord;
      if (wordDone) begin
        WordCount   <= WordCount + LEN_W'(1);
        Mem_Address <= Mem_Address + ADDR_W'(BYTES_PER_WORD);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven loads plus hand sequences for
// empty/oversize starts, reset mid-load, ignored Start and reload from DONE.
module tb_program_loader;

  logic        Clock = 1'b0;
  logic        Reset, Start, ByteValid;
  logic [14:0] Length;
  logic [7:0]  ByteIn;
  logic        ByteReady, Mem_MemWrite, CPU_Reset, Done, Error;
  logic [31:0] Mem_Address, Mem_WriteData;
  logic [14:0] WordCount;

  program_loader dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Length        (Length),
    .ByteIn        (ByteIn),
    .ByteValid     (ByteValid),
    .ByteReady     (ByteReady),
    .Mem_Address   (Mem_Address),
    .Mem_WriteData (Mem_WriteData),
    .Mem_MemWrite  (Mem_MemWrite),
    .CPU_Reset     (CPU_Reset),
    .Done          (Done),
    .Error         (Error),
    .WordCount     (WordCount)
  );

  always #5 Clock = ~Clock;

  int nVec = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wordOf(input int k);
    logic [7:0] b;
    b = 8'(k);
    if (k == 0) return 32'h8C01_0004;
    if (k == 1) return 32'hAC02_0008;
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  function automatic logic [7:0] byteOf(input int i);
    logic [31:0] w;
    w = wordOf(i / 4);
    case (i % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Write monitor and RAM model; also flags a write issued before its 4th byte.
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         wq[$];
  logic [31:0] ram [0:31];
  int          accBytes = 0;
  int          wrBase = 0, accBase = 0;
  bit          earlyWrite = 1'b0;

  always @(negedge Clock) begin
    wr_t w;
    if (Mem_MemWrite) begin
      if ((wq.size() - wrBase) >= ((accBytes - accBase) / 4)) earlyWrite = 1'b1;
      w.addr = Mem_Address;
      w.data = Mem_WriteData;
      wq.push_back(w);
      if (Mem_Address < 32'd128) ram[Mem_Address[6:2]] = Mem_WriteData;
    end
    if (ByteValid && ByteReady) accBytes++;
  end

  task automatic mark();
    wrBase  = wq.size();
    accBase = accBytes;
  endtask

  task automatic pulseStart(input logic [14:0] len);
    Start  = 1'b1;
    Length = len;
    @(posedge Clock); #1;
    Start  = 1'b0;
  endtask

  task automatic feed(input int len, input bit toggle, input int startAt, output bit readyBad);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    readyBad = 1'b0;
    while (idx < 4 * len && cyc < 40 * len + 20) begin
      ByteIn    = byteOf(idx);
      ByteValid = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == startAt) begin
        Start  = 1'b1;
        Length = 15'd1;
      end
      @(negedge Clock);
      xfer = ByteValid && ByteReady;
      if (!Mem_MemWrite && !ByteReady) readyBad = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      if (xfer) idx++;
      cyc++;
    end
    ByteValid = 1'b0;
    if (idx < 4 * len) check("feedTimeout", 32'(idx), 32'(4 * len));
  endtask

  task automatic waitDone();
    int c = 0;
    while (!Done && c < 20) begin
      @(posedge Clock); #1;
      c++;
    end
  endtask

  task automatic checkLoad(input string name, input int len, input logic [31:0] lastAddr, input bit readyBad);
    int n;
    n = wq.size() - wrBase;
    check({name, "_writes"}, 32'(n), 32'(len));
    for (int k = 0; k < len && k < n; k++) begin
      check({name, "_addr"}, wq[wrBase + k].addr, 32'(4 * k));
      check({name, "_data"}, wq[wrBase + k].data, wordOf(k));
    end
    if (n > 0) check({name, "_lastAddr"}, wq[wq.size() - 1].addr, lastAddr);
    check({name, "_done"},      32'(Done),       32'd1);
    check({name, "_cpuReset"},  32'(CPU_Reset),  32'd0);
    check({name, "_wordCount"}, 32'(WordCount),  32'(len));
    check({name, "_early"},     32'(earlyWrite), 32'd0);
    check({name, "_ready"},     32'(readyBad),   32'd0);
  endtask

  task automatic checkResetVals(input string name);
    check({name, "_byteReady"}, 32'(ByteReady),    32'd0);
    check({name, "_memWrite"},  32'(Mem_MemWrite), 32'd0);
    check({name, "_addr"},      Mem_Address,       32'd0);
    check({name, "_wdata"},     Mem_WriteData,     32'd0);
    check({name, "_cpuReset"},  32'(CPU_Reset),    32'd1);
    check({name, "_done"},      32'(Done),         32'd0);
    check({name, "_error"},     32'(Error),        32'd0);
    check({name, "_wordCount"}, 32'(WordCount),    32'd0);
  endtask

  typedef struct {
    int          len;
    bit          toggle;
    int          startAt;
    logic [31:0] expLastAddr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rb;
    vecs[0] = '{len: 2, toggle: 1'b0, startAt: -1, expLastAddr: 32'h4};
    vecs[1] = '{len: 2, toggle: 1'b1, startAt: -1, expLastAddr: 32'h4};
    vecs[2] = '{len: 5, toggle: 1'b1, startAt: -1, expLastAddr: 32'h10};
    vecs[3] = '{len: 3, toggle: 1'b0, startAt: -1, expLastAddr: 32'h8};

    Reset = 1'b1; Start = 1'b0; Length = '0; ByteIn = '0; ByteValid = 1'b0;
    repeat (2) @(posedge Clock); #1;
    checkResetVals("reset");
    Reset = 1'b0;
    @(posedge Clock); #1;

    // ByteValid in IDLE must not transfer
    mark();
    ByteValid = 1'b1; ByteIn = 8'hFF;
    repeat (2) @(posedge Clock); #1;
    ByteValid = 1'b0;
    check("idleNoXfer", 32'(accBytes - accBase), 32'd0);

    for (int v = 0; v < 4; v++) begin
      mark();
      pulseStart(15'(vecs[v].len));
      check($sformatf("vec%0d_cpuResetHeld", v), 32'(CPU_Reset), 32'd1);
      check($sformatf("vec%0d_doneLow", v),      32'(Done),      32'd0);
      feed(vecs[v].len, vecs[v].toggle, vecs[v].startAt, rb);
      waitDone();
      checkLoad($sformatf("vec%0d", v), vecs[v].len, vecs[v].expLastAddr, rb);
    end

    // Empty load completes immediately without writes
    mark();
    pulseStart(15'd0);
    check("len0_done",      32'(Done),      32'd1);
    check("len0_wordCount", 32'(WordCount), 32'd0);
    repeat (3) @(posedge Clock); #1;
    check("len0_noWrite",   32'(wq.size() - wrBase), 32'd0);

    // Oversize load flags Error and parks in IDLE
    pulseStart(15'd16385);
    check("oversize_error",    32'(Error),     32'd1);
    check("oversize_cpuReset", 32'(CPU_Reset), 32'd1);
    check("oversize_done",     32'(Done),      32'd0);
    check("oversize_ready",    32'(ByteReady), 32'd0);

    // Reset after two bytes of the first word
    mark();
    pulseStart(15'd3);
    check("midload_errorCleared", 32'(Error), 32'd0);
    ByteValid = 1'b1; ByteIn = 8'h8C;
    @(posedge Clock); #1;
    ByteIn = 8'h01;
    @(posedge Clock); #1;
    ByteValid = 1'b0;
    Reset = 1'b1;
    #2;
    checkResetVals("midload");
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("midload_noWrite", 32'(wq.size() - wrBase), 32'd0);
    @(posedge Clock); #1;

    mark();
    pulseStart(15'd1);
    feed(1, 1'b0, -1, rb);
    waitDone();
    checkLoad("restart", 1, 32'h0, rb);

    // Start during RECV is ignored; full 17-word image lands at 0x00..0x40
    mark();
    pulseStart(15'd17);
    feed(17, 1'b0, 6, rb);
    waitDone();
    checkLoad("len17", 17, 32'h40, rb);
    check("fetchPc0", ram[0], wordOf(0));

    // Reload from DONE re-asserts CPU reset
    mark();
    pulseStart(15'd1);
    check("reload_cpuReset",  32'(CPU_Reset), 32'd1);
    check("reload_done",      32'(Done),      32'd0);
    check("reload_wordCount", 32'(WordCount), 32'd0);
    feed(1, 1'b0, -1, rb);
    waitDone();
    checkLoad("reload", 1, 32'h0, rb);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
